// File: rtl/fp_norm_shifter_pipe_if.sv
// Handshake bundle for the post-add normaliser.
// The master side feeds adder results and accepts normalised results.
// The slave side is the normaliser itself.
interface fp_norm_shifter_pipe_if #(
    parameter int MANT_W = 27,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant;
    logic              in_ovf;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_uflow;
    logic              out_oflow;

    modport master (
        output in_valid, in_mant, in_ovf, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, out_oflow
    );

    modport slave (
        input  in_valid, in_mant, in_ovf, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, out_oflow
    );
endinterface

// File: rtl/fp_norm_shifter_pipe.sv
// Two-stage pipelined post-add normaliser for the FPU add path.
// Stage 1 captures the adder result and its leading-zero count; stage 2
// right-shifts on carry-out or left-normalises, updating the exponent and
// raising zero / underflow / overflow flags.
// Optional feature macro: NORM_STICKY_EN keeps the bit shifted out on a
// carry-out right shift as a sticky bit in out_mant[0].
module fp_norm_shifter_pipe #(
    parameter int MANT_W = 27,
    parameter int EXP_W  = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    fp_norm_shifter_pipe_if.slave bus
);
    localparam int LZC_W = $clog2(MANT_W + 1);
    localparam int XW    = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 2;

    logic [MANT_W-1:0] mant_p1;
    logic [EXP_W-1:0]  exp_p1;
    logic              ovf_p1;
    logic [LZC_W-1:0]  lzc_p1;
    logic              vld_p1;

    logic [MANT_W-1:0] mant_p2;
    logic [EXP_W-1:0]  exp_p2;
    logic              zero_p2;
    logic              uflow_p2;
    logic              oflow_p2;
    logic              vld_p2;

    logic              s1_load;
    logic              s2_load;

    logic [MANT_W-1:0] nx_mant;
    logic [EXP_W-1:0]  nx_exp;
    logic              nx_zero;
    logic              nx_uflow;
    logic              nx_oflow;
    logic [EXP_W:0]    inc;
    logic [LZC_W-1:0]  sh;
    logic signed [XW-1:0] exp_s;
    logic signed [XW-1:0] lzc_s;
    logic signed [XW-1:0] diff;

    // Leading-zero count; all-zero input reports MANT_W.
    function automatic logic [LZC_W-1:0] lead_zeros(input logic [MANT_W-1:0] m);
        logic [LZC_W-1:0] n;
        n = LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (m[i]) n = LZC_W'(MANT_W - 1 - i);
        end
        return n;
    endfunction

    // Saturating exponent increment: returns {oflow, exp}; reaching all-ones
    // (or starting there) saturates at all-ones instead of wrapping.
    function automatic logic [EXP_W:0] sat_inc(input logic [EXP_W-1:0] e);
        logic [EXP_W:0] sum;
        sum = {1'b0, e} + (EXP_W+1)'(1);
        if (sum >= {1'b0, {EXP_W{1'b1}}}) return {1'b1, {EXP_W{1'b1}}};
        return {1'b0, sum[EXP_W-1:0]};
    endfunction

    assign s2_load = !vld_p2 || bus.out_ready;
    assign s1_load = !vld_p1 || s2_load;

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = vld_p2;
    assign bus.out_mant  = mant_p2;
    assign bus.out_exp   = exp_p2;
    assign bus.out_zero  = zero_p2;
    assign bus.out_uflow = uflow_p2;
    assign bus.out_oflow = oflow_p2;

    // Stage 1: capture the adder result and its leading-zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            mant_p1 <= '0;
            exp_p1  <= '0;
            ovf_p1  <= 1'b0;
            lzc_p1  <= '0;
        end else if (s1_load) begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                mant_p1 <= bus.in_mant;
                exp_p1  <= bus.in_exp;
                ovf_p1  <= bus.in_ovf;
                lzc_p1  <= lead_zeros(bus.in_mant);
            end
        end
    end

    // Stage 2 datapath: carry-out right shift, zero, pass, normalise or denormal.
    always_comb begin
        nx_mant  = '0;
        nx_exp   = '0;
        nx_zero  = 1'b0;
        nx_uflow = 1'b0;
        nx_oflow = 1'b0;
        sh       = '0;
        inc      = sat_inc(exp_p1);
        exp_s    = $signed(XW'(exp_p1));
        lzc_s    = $signed(XW'(lzc_p1));
        diff     = exp_s - lzc_s;
        if (ovf_p1) begin
            nx_oflow = inc[EXP_W];
            nx_exp   = inc[EXP_W-1:0];
            if (!inc[EXP_W]) begin
                nx_mant = {1'b1, mant_p1[MANT_W-1:1]};
`ifdef NORM_STICKY_EN
                nx_mant[0] = mant_p1[1] | mant_p1[0];
`else
                nx_mant[0] = mant_p1[1];
`endif
            end
        end else if (mant_p1 == '0) begin
            nx_zero = 1'b1;
        end else if (lzc_p1 == '0) begin
            nx_mant = mant_p1;
            nx_exp  = exp_p1;
        end else if (diff > 0) begin
            nx_mant = mant_p1 << lzc_p1;
            nx_exp  = EXP_W'(diff);
        end else begin
            // Shift only as far as exponent 1 allows, then mark denormal.
            sh       = (exp_p1 == '0) ? '0 : LZC_W'(exp_p1 - EXP_W'(1));
            nx_mant  = mant_p1 << sh;
            nx_uflow = 1'b1;
        end
    end

    // Stage 2: output registers, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            mant_p2  <= '0;
            exp_p2   <= '0;
            zero_p2  <= 1'b0;
            uflow_p2 <= 1'b0;
            oflow_p2 <= 1'b0;
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                mant_p2  <= nx_mant;
                exp_p2   <= nx_exp;
                zero_p2  <= nx_zero;
                uflow_p2 <= nx_uflow;
                oflow_p2 <= nx_oflow;
            end
        end
    end
endmodule
